// File: rtl/car_warning_ctrl.sv
// Cabin warning controller: debounces body sensors and drives the chime and warning lamp.
// Ignition on with the door open or an occupied seat unbelted walks IDLE -> GRACE -> ALARM -> MUTE.
module car_warning_ctrl #(
    parameter int unsigned NUM_SEATS       = 2,
    parameter int unsigned DEBOUNCE_CYCLES = 4,
    parameter int unsigned GRACE_CYCLES    = 8,
    parameter int unsigned ALARM_CYCLES    = 32,
    parameter int unsigned BLINK_HALF      = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 door_close,
    input  logic                 ignition,
    input  logic [NUM_SEATS-1:0] seat_belt,
    input  logic [NUM_SEATS-1:0] seat_occupied,
    input  logic                 ack,
    output logic                 alarm,
    output logic                 lamp,
    output logic [NUM_SEATS-1:0] belt_warn,
    output logic [1:0]           state
);
    localparam int unsigned NIN  = 2 + 2 * NUM_SEATS;
    localparam int unsigned DOOR = NIN - 1;
    localparam int unsigned IGN  = NIN - 2;
    localparam int unsigned FW   = NUM_SEATS + 1;
    localparam int unsigned DW   = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int unsigned GW   = $clog2(GRACE_CYCLES + 1);
    localparam int unsigned AW   = $clog2(ALARM_CYCLES + 1);
    localparam int unsigned BW   = $clog2(BLINK_HALF + 1);
    localparam logic [NIN-1:0] FILT_RST = {1'b1, 1'b0, {NUM_SEATS{1'b1}}, {NUM_SEATS{1'b0}}};

    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_GRACE = 2'b01,
        S_ALARM = 2'b10,
        S_MUTE  = 2'b11
    } state_t;

    // Packed as {door, ignition, belts, occupancy}
    logic [NIN-1:0] raw;
    logic [NIN-1:0] filt_q;
    logic [NIN-2:0] filt_d;

    assign raw = {door_close, ignition, seat_belt, seat_occupied};

    // One debounce filter per input bit; a run of DEBOUNCE_CYCLES differing samples flips it
    for (genvar g = 0; g < NIN; g++) begin : g_deb
        logic          f_q;
        logic          f_d;
        logic [DW-1:0] c_q;
        logic [DW-1:0] c_d;

        always_comb begin
            f_d = f_q;
            c_d = '0;
            if (raw[g] != f_q) begin
                if (c_q == DW'(DEBOUNCE_CYCLES - 1)) begin
                    f_d = raw[g];
                end else begin
                    c_d = c_q + DW'(1);
                end
            end
        end

        always_ff @(posedge clk) begin
            if (reset) begin
                f_q <= FILT_RST[g];
                c_q <= '0;
            end else begin
                f_q <= f_d;
                c_q <= c_d;
            end
        end

        assign filt_q[g] = f_q;
        if (g < NIN - 1) begin : g_nxt
            assign filt_d[g] = f_d;
        end
    end

    logic [NUM_SEATS-1:0] warn;
    logic [NUM_SEATS-1:0] warn_d;
    logic [FW-1:0]        fvec;
    logic                 fault;

    assign warn   = {NUM_SEATS{filt_q[IGN]}} & filt_q[NUM_SEATS-1:0]
                  & ~filt_q[2*NUM_SEATS-1:NUM_SEATS];
    assign warn_d = {NUM_SEATS{filt_d[IGN]}} & filt_d[NUM_SEATS-1:0]
                  & ~filt_d[2*NUM_SEATS-1:NUM_SEATS];
    assign fvec   = {filt_q[IGN] & ~filt_q[DOOR], warn};
    assign fault  = |fvec;

    state_t        st_q, st_d;
    logic [GW-1:0] gcnt_q, gcnt_d;
    logic [AW-1:0] acnt_q, acnt_d;
    logic [BW-1:0] bcnt_q, bcnt_d;
    logic          phase_q, phase_d;
    logic [FW-1:0] latch_q, latch_d;
    logic          alarm_d;
    logic          lamp_d;

    // Next state, counters and next-cycle outputs
    always_comb begin
        st_d    = st_q;
        gcnt_d  = gcnt_q;
        acnt_d  = acnt_q;
        bcnt_d  = bcnt_q;
        phase_d = phase_q;
        latch_d = latch_q;
        if (!fault) begin
            st_d    = S_IDLE;
            gcnt_d  = '0;
            acnt_d  = '0;
            bcnt_d  = '0;
            phase_d = 1'b0;
            latch_d = '0;
        end else begin
            unique case (st_q)
                S_IDLE: begin
                    st_d   = S_GRACE;
                    gcnt_d = '0;
                end
                S_GRACE: begin
                    if (gcnt_q == GW'(GRACE_CYCLES - 1)) begin
                        st_d    = S_ALARM;
                        gcnt_d  = '0;
                        acnt_d  = '0;
                        bcnt_d  = '0;
                        phase_d = 1'b1;
                    end else begin
                        gcnt_d = gcnt_q + GW'(1);
                    end
                end
                S_ALARM: begin
                    if (ack || acnt_q == AW'(ALARM_CYCLES - 1)) begin
                        st_d    = S_MUTE;
                        acnt_d  = '0;
                        bcnt_d  = '0;
                        phase_d = 1'b0;
                        latch_d = fvec;
                    end else begin
                        acnt_d = acnt_q + AW'(1);
                        if (bcnt_q == BW'(BLINK_HALF - 1)) begin
                            bcnt_d  = '0;
                            phase_d = ~phase_q;
                        end else begin
                            bcnt_d = bcnt_q + BW'(1);
                        end
                    end
                end
                S_MUTE: begin
                    // Only a newly raised fault re-arms; cleared bits just shrink the latch
                    if (|(fvec & ~latch_q)) begin
                        st_d   = S_GRACE;
                        gcnt_d = '0;
                    end else begin
                        latch_d = fvec;
                    end
                end
            endcase
        end
        alarm_d = (st_d == S_ALARM);
        lamp_d  = (st_d == S_GRACE) || (st_d == S_MUTE) || ((st_d == S_ALARM) && phase_d);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            st_q      <= S_IDLE;
            gcnt_q    <= '0;
            acnt_q    <= '0;
            bcnt_q    <= '0;
            phase_q   <= 1'b0;
            latch_q   <= '0;
            alarm     <= 1'b0;
            lamp      <= 1'b0;
            belt_warn <= '0;
        end else begin
            st_q      <= st_d;
            gcnt_q    <= gcnt_d;
            acnt_q    <= acnt_d;
            bcnt_q    <= bcnt_d;
            phase_q   <= phase_d;
            latch_q   <= latch_d;
            alarm     <= alarm_d;
            lamp      <= lamp_d;
            belt_warn <= warn_d;
        end
    end

    assign state = st_q;

endmodule

// File: tb/tb_car_warning_ctrl.sv
// Directed bench for car_warning_ctrl: behavioural model compared every cycle plus literal checkpoints.
module tb_car_warning_ctrl;
    localparam int unsigned NS = 2;
    localparam int unsigned D  = 4;
    localparam int unsigned G  = 8;
    localparam int unsigned A  = 32;
    localparam int unsigned BH = 4;

    logic          clk;
    logic          reset;
    logic          door_close;
    logic          ignition;
    logic [NS-1:0] seat_belt;
    logic [NS-1:0] seat_occupied;
    logic          ack;
    logic          alarm;
    logic          lamp;
    logic [NS-1:0] belt_warn;
    logic [1:0]    state;

    car_warning_ctrl #(
        .NUM_SEATS(NS), .DEBOUNCE_CYCLES(D), .GRACE_CYCLES(G),
        .ALARM_CYCLES(A), .BLINK_HALF(BH)
    ) dut (
        .clk(clk), .reset(reset), .door_close(door_close), .ignition(ignition),
        .seat_belt(seat_belt), .seat_occupied(seat_occupied), .ack(ack),
        .alarm(alarm), .lamp(lamp), .belt_warn(belt_warn), .state(state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    bit check_en = 1'b0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", name, got, exp, $time);
        end
    endtask

    // Model: a filtered bit flips once the last D raw samples all disagree with it;
    // the FSM is tracked as (state, cycles spent in it). Bits: [5]door [4]ign [3:2]belt [1:0]occ.
    bit [5:0] hist[$];
    bit [5:0] mf = 6'b101100;
    int       m_state = 0;
    int       m_n = 0;
    bit [2:0] m_latch = 3'b000;

    function automatic bit [1:0] warn_of(input bit [5:0] f);
        return {f[4], f[4]} & f[1:0] & ~f[3:2];
    endfunction

    always @(posedge clk) begin
        bit [2:0] fv;
        bit       flip;
        fv = {mf[4] & ~mf[5], warn_of(mf)};
        if (reset) begin
            m_state = 0;
            m_n     = 0;
            m_latch = 3'b000;
            mf      = 6'b101100;
            hist.delete();
        end else begin
            if (fv == 3'b000) begin
                m_state = 0;
                m_n     = 0;
            end else begin
                case (m_state)
                    0: begin m_state = 1; m_n = 0; end
                    1: if (m_n == G - 1) begin m_state = 2; m_n = 0; end else m_n++;
                    2: if (ack || m_n == A - 1) begin
                           m_state = 3; m_n = 0; m_latch = fv;
                       end else m_n++;
                    default: if ((fv & ~m_latch) != 3'b000) begin
                                 m_state = 1; m_n = 0;
                             end else m_latch = fv;
                endcase
            end
            hist.push_back({door_close, ignition, seat_belt, seat_occupied});
            if (hist.size() > D) void'(hist.pop_front());
            for (int b = 0; b < 6; b++) begin
                flip = (hist.size() >= D);
                for (int k = 0; k < D; k++) begin
                    if (flip && hist[hist.size() - 1 - k][b] == mf[b]) flip = 1'b0;
                end
                if (flip) mf[b] = ~mf[b];
            end
        end
    end

    // Every cycle, outputs against the model
    always @(negedge clk) begin
        bit exp_lamp;
        if (check_en) begin
            exp_lamp = (m_state == 1) || (m_state == 3) ||
                       ((m_state == 2) && ((m_n / BH) % 2 == 0));
            chk("model_state", 32'(state), 32'(m_state));
            chk("model_alarm", 32'(alarm), 32'(m_state == 2));
            chk("model_lamp", 32'(lamp), 32'(exp_lamp));
            chk("model_beltwarn", 32'(belt_warn), 32'(warn_of(mf)));
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    bit saw_alarm;
    bit saw_busy;

    task automatic watch(input int n);
        repeat (n) begin
            @(negedge clk);
            if (alarm !== 1'b0) saw_alarm = 1'b1;
            if (state !== 2'b00) saw_busy = 1'b1;
        end
    endtask

    initial begin
        int       cnt;
        bit [15:0] pat;

        // Reset held with an ignition-on/door-open fault on the raw pins
        reset = 1'b1; door_close = 1'b0; ignition = 1'b1;
        seat_belt = 2'b11; seat_occupied = 2'b00; ack = 1'b0;
        cyc(1);
        check_en = 1'b1;
        cyc(2);
        chk("rst_state", 32'(state), 32'd0);
        chk("rst_alarm", 32'(alarm), 32'd0);
        chk("rst_lamp", 32'(lamp), 32'd0);
        chk("rst_beltwarn", 32'(belt_warn), 32'd0);
        reset = 1'b0;
        cyc(4);
        chk("filter_edge4_idle", 32'(state), 32'd0);
        cyc(1);
        chk("edge5_grace", 32'(state), 32'd1);
        chk("edge5_lamp", 32'(lamp), 32'd1);

        // Full GRACE then ALARM run with no ack
        cnt = 0;
        while (state == 2'b01 && cnt < 100) begin cnt++; cyc(1); end
        chk("grace_len", 32'(cnt), 32'd8);
        cnt = 0; pat = '0;
        while (state == 2'b10 && cnt < 100) begin
            if (cnt < 16) pat[15 - cnt] = lamp;
            cnt++;
            cyc(1);
        end
        chk("alarm_len", 32'(cnt), 32'd32);
        chk("blink_pattern", 32'(pat), 32'h0000F0F0);
        chk("mute_state", 32'(state), 32'd3);
        chk("mute_alarm", 32'(alarm), 32'd0);
        chk("mute_lamp", 32'(lamp), 32'd1);
        door_close = 1'b1;
        cyc(4);
        chk("door_settling_mute", 32'(state), 32'd3);
        cyc(1);
        chk("door_closed_idle", 32'(state), 32'd0);

        // Ignition pulse shorter than the filter with the door open
        ignition = 1'b0; door_close = 1'b0;
        cyc(6);
        saw_alarm = 1'b0; saw_busy = 1'b0;
        ignition = 1'b1;
        watch(3);
        ignition = 1'b0;
        watch(6);
        chk("pulse_no_leave_idle", 32'(saw_busy), 32'd0);
        chk("pulse_no_alarm", 32'(saw_alarm), 32'd0);
        chk("pulse_beltwarn", 32'(belt_warn), 32'd0);

        // Door closed again early in GRACE: filter clears in the 5th GRACE cycle
        ignition = 1'b1;
        cyc(5);
        chk("door_fault_grace", 32'(state), 32'd1);
        door_close = 1'b1;
        saw_alarm = 1'b0;
        watch(4);
        chk("door_reclose_still_grace", 32'(state), 32'd1);
        watch(1);
        chk("door_reclose_idle", 32'(state), 32'd0);
        chk("door_reclose_no_alarm", 32'(saw_alarm), 32'd0);

        // Seat 1 occupied and unbelted, ack in ALARM cycle 3, then seat 0 unbelted
        seat_occupied = 2'b10; seat_belt = 2'b01;
        cyc(4);
        chk("seat1_beltwarn", 32'(belt_warn), 32'h2);
        chk("seat1_idle", 32'(state), 32'd0);
        cyc(1);
        chk("seat1_grace", 32'(state), 32'd1);
        ack = 1'b1;
        cyc(2);
        ack = 1'b0;
        cyc(6);
        chk("ack_in_grace_ignored", 32'(state), 32'd2);
        cyc(2);
        ack = 1'b1;
        cyc(1);
        ack = 1'b0;
        chk("ack_mute", 32'(state), 32'd3);
        chk("ack_alarm_off", 32'(alarm), 32'd0);
        seat_occupied = 2'b11; seat_belt = 2'b00;
        cyc(4);
        chk("both_beltwarn", 32'(belt_warn), 32'h3);
        chk("both_still_mute", 32'(state), 32'd3);
        cyc(1);
        chk("new_fault_regrace", 32'(state), 32'd1);

        // Reset in ALARM cycle 10
        cyc(8);
        chk("rearm_alarm", 32'(state), 32'd2);
        cyc(9);
        reset = 1'b1;
        cyc(1);
        chk("midrst_alarm", 32'(alarm), 32'd0);
        chk("midrst_lamp", 32'(lamp), 32'd0);
        chk("midrst_state", 32'(state), 32'd0);
        chk("midrst_beltwarn", 32'(belt_warn), 32'd0);
        reset = 1'b0;

        // Post-reset refilter with ack toggling across states
        cyc(10);
        ack = 1'b1;
        cyc(3);
        ack = 1'b0;
        cyc(8);
        ack = 1'b1;
        cyc(1);
        ack = 1'b0;
        cyc(4);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/car_warning_ctrl.md
# car_warning_ctrl

Parametrised, clocked successor to the combinational car alarm. It debounces door, ignition, per-seat belt and per-seat occupancy inputs, then detects "ignition on with door open or an occupied seat unbelted". A fault first enters a grace period, then a timed chime with a blinking lamp, then a driver-mutable reminder state. The block sits between the raw body-sensor inputs and the cabin chime/lamp drivers.

## Interface
- NUM_SEATS, 2, number of seat channels; seat 0 is the driver.
- DEBOUNCE_CYCLES, 4, consecutive differing samples required before a filtered input changes (≥1).
- GRACE_CYCLES, 8, cycles spent in GRACE before the chime starts (≥1).
- ALARM_CYCLES, 32, maximum chime duration before auto-mute (≥1).
- BLINK_HALF, 4, lamp half-period in ALARM (≥1).
- Clk  input  1  system clock; all state updates on its rising edge.
- Reset  input  1  synchronous, active-high reset.
- DoorClose  input  1  1 = door closed.
- Ignition  input  1  1 = ignition on.
- SeatBelt  input  NUM_SEATS  bit i = 1: seat i belted.
- SeatOccupied  input  NUM_SEATS  bit i = 1: seat i occupied.
- Ack  input  1  driver mute request, level, not debounced.
- Alarm  output  1  chime drive.
- Lamp  output  1  warning lamp.
- BeltWarn  output  NUM_SEATS  per-seat unbelted indicator.
- State  output  2  FSM state: 00 IDLE, 01 GRACE, 10 ALARM, 11 MUTE.

## Operation
- Debounce: one filter per input bit, each with a filtered register and a counter of width $clog2(DEBOUNCE_CYCLES+1).
  - Raw == filtered → counter cleared.
  - Raw != filtered → counter increments. On the DEBOUNCE_CYCLES-th consecutive differing edge, filtered ← raw and counter clears.
- Filtered reset values: DoorClose 1, Ignition 0, SeatBelt all 1, SeatOccupied all 0.
- BeltWarn[i] = Ign_f & Occ_f[i] & ~Belt_f[i]. Combinational from the filtered registers and valid in every state.
- FaultVec = {~Door_f, BeltWarn} gated by Ign_f. Fault = |FaultVec.
- FSM transitions, evaluated each edge in priority order:
  1. Reset → IDLE.
  2. Not Fault (including ignition off) → IDLE from any state.
  3. IDLE: Fault → GRACE; grace counter cleared.
  4. GRACE: counter counts 0..GRACE_CYCLES-1; at GRACE_CYCLES-1 → ALARM; alarm counter cleared; blink phase = 1.
  5. ALARM: Ack = 1 or alarm counter at ALARM_CYCLES-1 → MUTE. Both in the same cycle → MUTE.
  6. MUTE: any FaultVec bit newly set versus the vector latched on MUTE entry → GRACE. A cleared bit updates the latch and causes no transition.
- Outputs per state:
  - IDLE: Alarm 0, Lamp 0.
  - GRACE: Alarm 0, Lamp 1.
  - ALARM: Alarm 1, Lamp = blink phase. The phase toggles every BLINK_HALF cycles, starting at 1.
  - MUTE: Alarm 0, Lamp 1.
- Ack outside ALARM is ignored.
- All counters saturate or clear on state exit and never wrap within a state.

## Timing
- Reset values: Alarm 0, Lamp 0, BeltWarn 0, State 00. All counters and the latched FaultVec are 0.
- Reset asserted mid-operation takes effect at the next edge, regardless of inputs.
- Input change held stable from edge k:
  - Filtered value changes at edge k+DEBOUNCE_CYCLES-1, counting edge k as the first sample.
  - BeltWarn changes in the same cycle.
  - State leaves IDLE one edge later.
- GRACE lasts exactly GRACE_CYCLES cycles. ALARM lasts at most ALARM_CYCLES cycles.
- Ack latency: the edge sampling Ack = 1 in ALARM moves State to MUTE. Alarm is 0 in the following cycle.
- Blink pattern in ALARM with BLINK_HALF = 4: Lamp 1,1,1,1,0,0,0,0,1,… from the first ALARM cycle.
- Fault clearing in the same cycle as the GRACE terminal count or as Ack → IDLE; IDLE has priority.

## Test plan
- Reset with Ignition = 1, DoorClose = 0 held → outputs 0 and State 00 during reset. After release, State 01 at the 5th edge, Lamp 1.
- Ignition pulsed high for 3 cycles with the door open → State stays 00, BeltWarn 0, Alarm never asserts.
- Door open, ignition on, no Ack → 8 GRACE cycles, then 32 ALARM cycles with Alarm 1 and Lamp 11110000… . Then MUTE with Alarm 0 and Lamp 1. Closing the door → IDLE once the filter settles.
- Door fault with the door closed again at GRACE cycle 5 → IDLE once the filter settles; Alarm never asserts.
- Ignition on, SeatOccupied = 2'b10, SeatBelt = 2'b01 → BeltWarn 2'b10. Ack = 1 at ALARM cycle 3 → MUTE. Then unbelting seat 0 (after Occ 2'b11) → BeltWarn 2'b11 and State → GRACE.
- Reset asserted at ALARM cycle 10 → next edge Alarm 0, Lamp 0, State 00, BeltWarn 0.
